// File: rtl/bin_to_bcd_feed.sv
// bin_to_bcd_feed: iterative shift-and-add-3 binary-to-BCD converter that
// feeds the four-digit seven-segment display driver (num_in format).
// The last result is held steady between conversions so the display scans
// a stable value.
// Optional build macro: BIN2BCD_SATURATE_EN. When defined, overflow inputs
// show 9999. When undefined, they show EEEE. Either way ovf=1.
module bin_to_bcd_feed #(
  parameter int BIN_W = 14
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BIN_W-1:0] bin_in,
  output logic [0:15]      bcd_out,
  output logic             out_valid,
  output logic             ovf
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [4:0]       LAST  = 5'(BIN_W - 1);
  localparam logic [BIN_W-1:0] LIMIT = BIN_W'(9999);
`ifdef BIN2BCD_SATURATE_EN
  localparam logic [15:0]      OVF_VAL = 16'h9999;
`else
  localparam logic [15:0]      OVF_VAL = 16'hEEEE;
`endif

  state_t           state, state_nxt;
  logic [BIN_W-1:0] sr;
  logic [15:0]      acc;
  logic [15:0]      adj;
  logic [4:0]       cnt;
  logic             ovf_flag;

  // Per-nibble correction: 4-bit add of 3 to any digit >= 5, no inter-nibble carry.
  always_comb begin
    adj = acc;
    for (int i = 0; i < 4; i++)
      if (acc[4*i +: 4] >= 4'd5) adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
  end

  assign in_ready = (state == IDLE);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = SHIFT;
      SHIFT:   if (cnt == LAST) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: capture, shift/correct, and the single-edge output update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr        <= '0;
      acc       <= '0;
      cnt       <= '0;
      ovf_flag  <= 1'b0;
      bcd_out   <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: if (in_valid) begin
          sr       <= bin_in;
          acc      <= '0;
          cnt      <= '0;
          ovf_flag <= (bin_in > LIMIT);
        end
        SHIFT: begin
          // Top accumulator bit falls off; only happens for overflow inputs.
          acc <= 16'({adj, sr[BIN_W-1]});
          sr  <= {sr[BIN_W-2:0], 1'b0};
          cnt <= cnt + 5'd1;
        end
        DONE: begin
          // All 16 bits load together so the display never sees a torn value.
          bcd_out   <= ovf_flag ? OVF_VAL : acc;
          ovf       <= ovf_flag;
          out_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_feed.sv
// Testbench for bin_to_bcd_feed: vector table plus corner-case sequences,
// with a scoreboard queue checked whenever out_valid pulses.
module tb_bin_to_bcd_feed;
  localparam int BIN_W = 14;
`ifdef BIN2BCD_SATURATE_EN
  localparam logic [15:0] OVFV = 16'h9999;
`else
  localparam logic [15:0] OVFV = 16'hEEEE;
`endif

  logic             clk = 0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [BIN_W-1:0] bin_in;
  logic [0:15]      bcd_out;
  logic             out_valid;
  logic             ovf;

  bin_to_bcd_feed #(.BIN_W(BIN_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .bin_in(bin_in), .bcd_out(bcd_out), .out_valid(out_valid), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [BIN_W-1:0] bin;
    logic [15:0]      bcd;
    logic             ovf;
  } vec_t;

  typedef struct {
    logic [15:0] bcd;
    logic        ovf;
    int          acc_cyc;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   ov_cnt = 0;
  int   last_acc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard check on every out_valid pulse.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      exp_t e;
      ov_cnt++;
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_out_valid: got bcd=%h at cycle %0d, required no pulse", bcd_out, cyc);
      end else begin
        e = sb.pop_front();
        if (bcd_out !== e.bcd) begin
          fails++;
          $display("FAIL bcd_out: got %h, required %h", bcd_out, e.bcd);
        end
        tests++;
        if (ovf !== e.ovf) begin
          fails++;
          $display("FAIL ovf: got %b, required %b (bcd %h)", ovf, e.ovf, e.bcd);
        end
        tests++;
        if (cyc - e.acc_cyc != BIN_W + 1) begin
          fails++;
          $display("FAIL latency: got %0d edges, required %0d", cyc - e.acc_cyc, BIN_W + 1);
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [BIN_W-1:0] b, input logic [15:0] eb,
                      input logic eo, input bit keep);
    bit ok = 0;
    in_valid = 1'b1;
    bin_in   = b;
    for (int i = 0; i < 200; i++) begin
      if (in_ready) begin ok = 1; break; end
      @(negedge clk);
    end
    if (ok) begin
      last_acc = cyc + 1;
      sb.push_back('{eb, eo, cyc + 1});
      @(posedge clk); #1;
      if (!keep) in_valid = 1'b0;
      @(negedge clk);
    end else begin
      tests++; fails++;
      $display("FAIL handshake_timeout: in_ready=%b, required 1 within 200 cycles", in_ready);
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_done();
    bit ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (sb.size() == 0) begin ok = 1; break; end
    end
    @(negedge clk);
    if (!ok) begin
      tests++; fails++;
      $display("FAIL result_timeout: %0d results pending, required 0", sb.size());
    end
  endtask

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] req);
    tests++;
    if (got !== req) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, got, req);
    end
  endtask

  initial begin
    vec_t vt[7];
    int a0, a1, a2, c0;
    bit bad;
    vt[0] = '{14'd1234,  16'h1234, 1'b0};
    vt[1] = '{14'd0,     16'h0000, 1'b0};
    vt[2] = '{14'd9999,  16'h9999, 1'b0};
    vt[3] = '{14'h0009,  16'h0009, 1'b0};
    vt[4] = '{14'd10000, OVFV,     1'b1};
    vt[5] = '{14'd16383, OVFV,     1'b1};
    vt[6] = '{14'd8765,  16'h8765, 1'b0};

    rst = 1'b1; in_valid = 1'b0; bin_in = '0;
    repeat (3) @(negedge clk);
    chk("reset_in_ready", 16'(in_ready), 16'h1);
    chk("reset_bcd_out", bcd_out, 16'h0000);
    chk("reset_ovf", 16'(ovf), 16'h0);
    chk("reset_out_valid", 16'(out_valid), 16'h0);
    rst = 1'b0;
    @(negedge clk);

    // Table-driven conversions, each checked on its own.
    for (int i = 0; i < 7; i++) begin
      send(vt[i].bin, vt[i].bcd, vt[i].ovf, 1'b0);
      wait_done();
      chk("held_bcd_out", bcd_out, vt[i].bcd);
    end

    // in_valid held high with changing data: one acceptance per 16 cycles.
    send(14'd5, 16'h0005, 1'b0, 1'b1);   a0 = last_acc;
    send(14'd42, 16'h0042, 1'b0, 1'b1);  a1 = last_acc;
    send(14'd700, 16'h0700, 1'b0, 1'b0); a2 = last_acc;
    wait_done();
    chk("throughput_1", 16'(a1 - a0), 16'd16);
    chk("throughput_2", 16'(a2 - a1), 16'd16);
    chk("hold_final_bcd", bcd_out, 16'h0700);

    // Reset mid-conversion of 4321.
    send(14'd4321, 16'h4321, 1'b0, 1'b0);
    repeat (6) @(negedge clk);
    rst = 1'b1;
    sb.delete();
    c0 = ov_cnt;
    repeat (2) @(negedge clk);
    chk("abort_bcd_out", bcd_out, 16'h0000);
    chk("abort_ovf", 16'(ovf), 16'h0);
    chk("abort_in_ready", 16'(in_ready), 16'h1);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("abort_no_out_valid", 16'(ov_cnt - c0), 16'h0);
    send(14'd4321, 16'h4321, 1'b0, 1'b0);
    wait_done();
    chk("post_abort_bcd", bcd_out, 16'h4321);

    // Idle for 100 cycles: outputs hold, no pulses.
    bad = 0;
    c0 = ov_cnt;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bcd_out !== 16'h4321 || ovf !== 1'b0 || out_valid !== 1'b0) bad = 1;
    end
    chk("idle_hold", 16'(bad), 16'h0);
    chk("idle_no_pulse", 16'(ov_cnt - c0), 16'h0);
    chk("scoreboard_empty", 16'(sb.size()), 16'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1, "timeout");
  end
endmodule
